// File: rtl/epm3032_ym2149_x2.sv
// Glue logic for a dual YM2149 (TurboSound-style) card on a ZX Spectrum Z80 bus.
// Decodes AY ports #FFFD/#BFFD into BC1/BDIR, selects one of two PSGs, divides
// the CPU clock by two for the PSGs and drives beeper, tape-out, covox strobe
// and IORQGE.
//
// Ports:
//   i_cpu_clock            Z80 CPU clock, the only clock (rising edge)
//   i_reset                synchronous active-high reset
//   i_a0..i_a2,i_a14,i_a15 Z80 address bits
//   i_m1,i_iorq,i_rd,i_wr  Z80 strobes, active-low
//   i_dos                  TR-DOS ROM active, active-low
//   i_d_0,i_d_4..i_d_7     Z80 data bits
//   o_bc1,o_bdir           YM2149 bus control, shared by both chips
//   o_ym_0,o_ym_1          PSG chip selects, active-low
//   o_ym_clock             PSG clock, cpu_clock / 2
//   o_beeper,o_tapeout     port #FE bits 4 and 0
//   o_covox                covox latch strobe, active-low
//   o_ioge_c               IORQGE, high while the PSG answers a read
module epm3032_ym2149_x2 (
    input  logic i_cpu_clock,
    input  logic i_reset,
    input  logic i_a0,
    input  logic i_a1,
    input  logic i_a2,
    input  logic i_a14,
    input  logic i_a15,
    input  logic i_m1,
    input  logic i_iorq,
    input  logic i_rd,
    input  logic i_wr,
    input  logic i_dos,
    input  logic i_d_0,
    input  logic i_d_4,
    input  logic i_d_5,
    input  logic i_d_6,
    input  logic i_d_7,
    output logic o_bc1,
    output logic o_bdir,
    output logic o_ym_0,
    output logic o_ym_1,
    output logic o_ym_clock,
    output logic o_beeper,
    output logic o_tapeout,
    output logic o_covox,
    output logic o_ioge_c
);

    logic w_io_cyc;
    logic w_ay_sel;
    logic w_chip_wr;
    logic w_fe_wr;

    logic r_chip_sel;
    logic r_ym_clock;
    logic r_beeper;
    logic r_tapeout;

    // Interrupt acknowledge (m1 and iorq both low) is not an I/O cycle.
    assign w_io_cyc = ~i_iorq & i_m1;
    assign w_ay_sel = w_io_cyc & i_a15 & ~i_a1;

    assign o_bc1    = w_ay_sel & i_a14 & (~i_rd | ~i_wr);
    assign o_bdir   = w_ay_sel & ~i_wr;
    assign o_ioge_c = w_ay_sel & i_a14 & ~i_rd;

    // Address-latch write whose upper nibble is #F is a chip-select command.
    assign w_chip_wr = o_bc1 & o_bdir & i_d_7 & i_d_6 & i_d_5 & i_d_4;
    assign w_fe_wr   = w_io_cyc & ~i_wr & ~i_a0;

    // Port #FB, muted while the TR-DOS ROM owns the bus.
    assign o_covox = ~(w_io_cyc & ~i_wr & i_dos & ~i_a2 & i_a1 & i_a0);

    always_ff @(posedge i_cpu_clock) begin
        if (i_reset) begin
            r_chip_sel <= 1'b0;
            r_ym_clock <= 1'b0;
            r_beeper   <= 1'b0;
            r_tapeout  <= 1'b0;
        end else begin
            r_ym_clock <= ~r_ym_clock;
            if (w_chip_wr) begin
                // #FF selects PSG 0, #FE selects PSG 1.
                r_chip_sel <= ~i_d_0;
            end
            if (w_fe_wr) begin
                r_beeper  <= i_d_4;
                r_tapeout <= i_d_0;
            end
        end
    end

    assign o_ym_0     = r_chip_sel;
    assign o_ym_1     = ~r_chip_sel;
    assign o_ym_clock = r_ym_clock;
    assign o_beeper   = r_beeper;
    assign o_tapeout  = r_tapeout;

endmodule

// File: tb/tb_epm3032_ym2149_x2.sv
`timescale 1ns/1ps
module tb_epm3032_ym2149_x2;

    logic clk = 1'b0;
    int   half_ns = 143;
    always #(half_ns) clk = ~clk;

    // Bus state driven by the tasks.
    logic        reset = 1'b0;
    logic [15:0] bus_addr = 16'hFFFF;
    logic [7:0]  bus_d = 8'h00;
    logic        bus_m1 = 1'b1, bus_iorq = 1'b1, bus_rd = 1'b1, bus_wr = 1'b1, bus_dos = 1'b1;

    logic bc1, bdir, ym_0, ym_1, ym_clock, beeper, tapeout, covox, ioge_c;

    int n_pass = 0;
    int n_total = 0;

    epm3032_ym2149_x2 dut (
        .i_cpu_clock(clk),
        .i_reset    (reset),
        .i_a0       (bus_addr[0]),
        .i_a1       (bus_addr[1]),
        .i_a2       (bus_addr[2]),
        .i_a14      (bus_addr[14]),
        .i_a15      (bus_addr[15]),
        .i_m1       (bus_m1),
        .i_iorq     (bus_iorq),
        .i_rd       (bus_rd),
        .i_wr       (bus_wr),
        .i_dos      (bus_dos),
        .i_d_0      (bus_d[0]),
        .i_d_4      (bus_d[4]),
        .i_d_5      (bus_d[5]),
        .i_d_6      (bus_d[6]),
        .i_d_7      (bus_d[7]),
        .o_bc1      (bc1),
        .o_bdir     (bdir),
        .o_ym_0     (ym_0),
        .o_ym_1     (ym_1),
        .o_ym_clock (ym_clock),
        .o_beeper   (beeper),
        .o_tapeout  (tapeout),
        .o_covox    (covox),
        .o_ioge_c   (ioge_c)
    );

    // ---------------- reference model ----------------
    // Which PSG (0 or 1) is selected, plus the #FE bits and the PSG clock phase.
    int   m_psg = 0;
    logic m_beeper = 1'b0, m_tapeout = 1'b0, m_ymclk = 1'b0;

    function automatic bit is_io(input logic iorq, input logic m1);
        return (iorq == 1'b0) && (m1 == 1'b1);
    endfunction

    // AY register-select port family (#FFFD and mirrors): A15=1, A14=1, A1=0.
    function automatic bit is_ay_reg_port(input logic [15:0] a);
        return a[15] && a[14] && !a[1];
    endfunction

    // AY data port family (#BFFD and mirrors): A15=1, A14=0, A1=0.
    function automatic bit is_ay_data_port(input logic [15:0] a);
        return a[15] && !a[14] && !a[1];
    endfunction

    // Expected {bc1, bdir, covox, ioge_c} from the PSG bus-mode table.
    function automatic logic [3:0] exp_comb(input logic [15:0] a, input logic iorq,
                                            input logic m1, input logic rd, input logic wr,
                                            input logic dos);
        logic b1, bd, cv, ig;
        bit io;
        io = is_io(iorq, m1);
        b1 = 1'b0; bd = 1'b0; ig = 1'b0;
        if (io && is_ay_reg_port(a)) begin
            if (!wr) begin b1 = 1'b1; bd = 1'b1; end       // latch address
            else if (!rd) begin b1 = 1'b1; end             // read data
            if (!rd) ig = 1'b1;
        end else if (io && is_ay_data_port(a)) begin
            if (!wr) bd = 1'b1;                            // write data
        end
        cv = !(io && !wr && dos && (a[7:0] & 8'h07) == 8'h03);
        return {b1, bd, cv, ig};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_psg <= 0; m_beeper <= 1'b0; m_tapeout <= 1'b0; m_ymclk <= 1'b0;
        end else begin
            m_ymclk <= ~m_ymclk;
            if (is_io(bus_iorq, bus_m1) && !bus_wr && is_ay_reg_port(bus_addr) &&
                bus_d[7:4] == 4'hF)
                m_psg <= bus_d[0] ? 0 : 1;
            if (is_io(bus_iorq, bus_m1) && !bus_wr && (bus_addr % 2 == 0)) begin
                m_beeper  <= bus_d[4];
                m_tapeout <= bus_d[0];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic iorq,
                         input logic m1, input logic rd, input logic wr, input logic dos);
        bus_addr = a; bus_d = d; bus_iorq = iorq; bus_m1 = m1;
        bus_rd = rd; bus_wr = wr; bus_dos = dos;
    endtask

    task automatic idle();
        drive(16'hFFFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if ({ym_0, ym_1, beeper, tapeout, ym_clock} !== 5'b01000)
            $display("FAIL reset_regs got %b expected 01000",
                     {ym_0, ym_1, beeper, tapeout, ym_clock});
        else n_pass++;
        n_total++;
        if ({bc1, bdir, covox, ioge_c} !== 4'b0010)
            $display("FAIL reset_comb got %b expected 0010", {bc1, bdir, covox, ioge_c});
        else n_pass++;
    endtask

    task automatic test_ay_decode();
        logic [15:0] addrs [4] = '{16'hBFFD, 16'hFFFD, 16'hFFFD, 16'h7FFD};
        logic        rds   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        wrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  exps  [4] = '{4'b0110, 4'b1110, 4'b1011, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 8'h00, 1'b0, 1'b1, rds[i], wrs[i], 1'b1);
            #1;
            n_total++;
            if ({bc1, bdir, covox, ioge_c} !== exps[i])
                $display("FAIL ay_decode[%0d] got %b expected %b", i,
                         {bc1, bdir, covox, ioge_c}, exps[i]);
            else n_pass++;
        end
        drive(16'h7FFD, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        n_total++;
        if ({bc1, bdir} !== 2'b00)
            $display("FAIL ay_7ffd_write got %b expected 00", {bc1, bdir});
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_chip_select();
        // #FE held for two edges: repeated sampling must be harmless.
        drive(16'hFFFD, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        idle();
        n_total++;
        if ({ym_0, ym_1} !== 2'b10) $display("FAIL cs_fe got %b expected 10", {ym_0, ym_1});
        else n_pass++;
        drive(16'hFFFD, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        n_total++;
        if ({ym_0, ym_1} !== 2'b01) $display("FAIL cs_ff got %b expected 01", {ym_0, ym_1});
        else n_pass++;
        drive(16'hFFFD, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        n_total++;
        if ({ym_0, ym_1} !== 2'b01) $display("FAIL cs_0e got %b expected 01", {ym_0, ym_1});
        else n_pass++;
        // Reset wins over a simultaneous select write.
        drive(16'hFFFD, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        n_total++;
        if ({ym_0, ym_1} !== 2'b01)
            $display("FAIL cs_reset_wins got %b expected 01", {ym_0, ym_1});
        else n_pass++;
    endtask

    task automatic test_fe_port();
        drive(16'h0001, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        n_total++;
        if ({beeper, tapeout} !== 2'b00)
            $display("FAIL fe_odd_port got %b expected 00", {beeper, tapeout});
        else n_pass++;
        drive(16'h00FE, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        n_total++;
        if (beeper !== 1'b0) $display("FAIL fe_before_edge got %b expected 0", beeper);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if ({beeper, tapeout} !== 2'b11)
            $display("FAIL fe_write got %b expected 11", {beeper, tapeout});
        else n_pass++;
    endtask

    task automatic test_covox_m1();
        drive(16'h00FB, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        n_total++;
        if (covox !== 1'b0) $display("FAIL covox_dos1 got %b expected 0", covox);
        else n_pass++;
        drive(16'h00FB, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        n_total++;
        if (covox !== 1'b1) $display("FAIL covox_dos0 got %b expected 1", covox);
        else n_pass++;
        drive(16'hFFFD, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        n_total++;
        if ({bc1, bdir, ioge_c} !== 3'b000)
            $display("FAIL inta_decode got %b expected 000", {bc1, bdir, ioge_c});
        else n_pass++;
        tick();
        idle();
        n_total++;
        if ({ym_0, ym_1} !== 2'b01)
            $display("FAIL inta_no_select got %b expected 01", {ym_0, ym_1});
        else n_pass++;
    endtask

    task automatic test_ym_clock();
        int   t0, t1;
        bit   found;
        idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (ym_clock !== m_ymclk)
                $display("FAIL ym_toggle[%0d] got %b expected %b", i, ym_clock, m_ymclk);
            else n_pass++;
        end
        half_ns = 71;  // turbo: 7 MHz
        tick(); tick(); tick();
        found = 1'b0;
        t0 = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(posedge clk);
            t0 = int'($time);
            #1;
            if (ym_clock === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL ym_turbo_high got %b expected 1", ym_clock);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        t1 = int'($time);
        #1;
        n_total++;
        if (ym_clock !== 1'b1 || (t1 - t0) != 4 * half_ns)
            $display("FAIL ym_turbo_period got %0d ns expected %0d ns", t1 - t0, 4 * half_ns);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] ports [7] = '{16'hFFFD, 16'hBFFD, 16'h7FFD, 16'h00FE,
                                   16'h00FB, 16'h0001, 16'h0000};
        logic [15:0] a;
        logic [7:0]  d;
        logic [3:0]  e;
        for (int i = 0; i < 400; i++) begin
            a = ports[$urandom_range(0, 6)];
            if (a == 16'h0000) a = 16'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[7:4] = 4'hF;
            reset = ($urandom_range(0, 39) == 0);
            drive(a, d, 1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom),
                  1'($urandom), 1'($urandom));
            #1;
            e = exp_comb(bus_addr, bus_iorq, bus_m1, bus_rd, bus_wr, bus_dos);
            n_total++;
            if ({bc1, bdir, covox, ioge_c} !== e)
                $display("FAIL rnd_comb[%0d] addr=%h got %b expected %b", i, a,
                         {bc1, bdir, covox, ioge_c}, e);
            else n_pass++;
            tick();
            n_total++;
            if ({ym_0, ym_1, beeper, tapeout, ym_clock} !==
                {m_psg != 0, m_psg != 1, m_beeper, m_tapeout, m_ymclk})
                $display("FAIL rnd_regs[%0d] got %b expected %b", i,
                         {ym_0, ym_1, beeper, tapeout, ym_clock},
                         {m_psg != 0, m_psg != 1, m_beeper, m_tapeout, m_ymclk});
            else n_pass++;
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        #5;
        test_reset();
        test_ay_decode();
        test_chip_select();
        test_fe_port();
        test_covox_m1();
        test_random();
        test_ym_clock();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
